// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - pipeline status in, hazard control out
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic             mem_branch;
  logic             mem_alu_zero;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic             ext_stall;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             pc_write;
  logic             if_id_write;
  logic             pipe_hold;
  logic             pc_sel;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       state;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  // Pipeline side: drives stage status, observes control.
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
           mem_rd, mem_reg_write, mem_branch, mem_alu_zero, wb_rd, wb_reg_write,
           ext_stall,
    input  forward_a, forward_b, pc_write, if_id_write, pipe_hold, pc_sel,
           if_id_flush, id_ex_flush, ex_mem_flush, state, timeout_err,
           stall_cnt, flush_cnt, freeze_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
           mem_rd, mem_reg_write, mem_branch, mem_alu_zero, wb_rd, wb_reg_write,
           ext_stall,
    output forward_a, forward_b, pc_write, if_id_write, pipe_hold, pc_sel,
           if_id_flush, id_ex_flush, ex_mem_flush, state, timeout_err,
           stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - RV64 5-stage forwarding/stall/flush/freeze control (HAZARD_PERF_CNT_EN enables perf counters)
module pipeline_hazard_controller #(
  parameter int FREEZE_TIMEOUT = 16,
  parameter int CNT_W          = 32
) (
  input logic                        clk,
  input logic                        reset,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10,
    FREEZE = 2'b11
  } state_t;

  localparam int FW = (FREEZE_TIMEOUT < 2) ? 1 : $clog2(FREEZE_TIMEOUT + 1);
  localparam logic [FW-1:0] FREEZE_MAX = FW'(FREEZE_TIMEOUT);

  state_t        state_q;
  state_t        next_state;
  logic [FW-1:0] freeze_run_q;
  logic          timeout_err_q;
  logic          load_use;
  logic          br_taken;

  // EX_MEM result is newer than MEM_WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       w_we,
    input logic [4:0] w_rd
  );
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))      return 2'b10;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  // Hazard conditions derived from the stage registers.
  always_comb begin
    load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
               ((bus.ex_rd == bus.id_rs1) ||
                (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
    br_taken = bus.mem_branch && bus.mem_alu_zero;
  end

  // Priority resolution: freeze > branch flush > load-use stall > run.
  always_comb begin
    next_state       = RUN;
    bus.forward_a    = 2'b00;
    bus.forward_b    = 2'b00;
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.pipe_hold    = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    if (!reset) begin
      bus.forward_a = fwd_sel(bus.ex_rs1, bus.mem_reg_write, bus.mem_rd,
                              bus.wb_reg_write, bus.wb_rd);
      bus.forward_b = fwd_sel(bus.ex_rs2, bus.mem_reg_write, bus.mem_rd,
                              bus.wb_reg_write, bus.wb_rd);
      if (bus.ext_stall) begin
        // A taken branch waiting in EX_MEM is kept and handled after the freeze.
        next_state      = FREEZE;
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        bus.pipe_hold   = 1'b1;
      end else if (br_taken) begin
        // The load-use consumer is squashed, so no bubble is needed.
        next_state       = FLUSH;
        bus.pc_sel       = 1'b1;
        bus.if_id_flush  = 1'b1;
        bus.id_ex_flush  = 1'b1;
        bus.ex_mem_flush = 1'b1;
      end else if (load_use) begin
        next_state      = STALL;
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        bus.id_ex_flush = 1'b1;
      end
    end
  end

  // State register records the case that won last cycle.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= next_state;
  end

  // Consecutive freeze tracking with a sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      freeze_run_q  <= '0;
      timeout_err_q <= 1'b0;
    end else if (bus.ext_stall) begin
      if (freeze_run_q != FREEZE_MAX) freeze_run_q <= freeze_run_q + 1'b1;
      if (freeze_run_q + 1'b1 >= FREEZE_MAX) timeout_err_q <= 1'b1;
    end else begin
      freeze_run_q <= '0;
    end
  end

  assign bus.state       = state_q;
  assign bus.timeout_err = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] freeze_cnt_q;

  // Free-running event counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (next_state == STALL)  stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (next_state == FLUSH)  flush_cnt_q  <= flush_cnt_q + 1'b1;
      if (next_state == FREEZE) freeze_cnt_q <= freeze_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.freeze_cnt = freeze_cnt_q;
`else
  assign bus.stall_cnt  = {CNT_W{1'b0}};
  assign bus.flush_cnt  = {CNT_W{1'b0}};
  assign bus.freeze_cnt = {CNT_W{1'b0}};
`endif

endmodule
